paddle_pos_ctrl: RTL and testbench

//   Parametrised position controller for the player paddle/cursor. Takes the two raw

---
 rtl/paddle_pos_ctrl.sv | 167 ++++++++++++++++
 tb/tb_paddle_pos_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/paddle_pos_ctrl.sv
// Paddle/cursor position controller: synchronises and debounces two active-low buttons,
// then drives a bounded, saturating position counter with slow/fast auto-repeat on tick.
module paddle_pos_ctrl #(
    parameter int WIDTH        = 10,
    parameter int MIN_POS      = 15,
    parameter int MAX_POS      = 624,
    parameter int RESET_POS    = 320,
    parameter int STEP         = 1,
    parameter int FAST_STEP    = 4,
    parameter int HOLD_TICKS   = 8,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pb_r_n,
    input  logic             pb_l_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] pos,
    output logic [1:0]       dir,
    output logic             at_min,
    output logic             at_max,
    output logic             moving
);

    localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW  = $clog2(HOLD_TICKS + 1);

    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_POS);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_POS);
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_POS);
    localparam logic [WIDTH:0]   MIN_W1  = (WIDTH+1)'(MIN_POS);
    localparam logic [WIDTH:0]   MAX_W1  = (WIDTH+1)'(MAX_POS);
    localparam logic [WIDTH:0]   STEP_V  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   FSTEP_V = (WIDTH+1)'(FAST_STEP);

    localparam logic [1:0] DIR_L = 2'b00;
    localparam logic [1:0] DIR_R = 2'b01;
    localparam logic [1:0] DIR_H = 2'b10;

    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

    // index 0 = right button, index 1 = left button
    logic [1:0]     raw;
    logic [1:0]     s1;
    logic [1:0]     s2;
    logic [1:0]     db;
    logic [DBW-1:0] db_cnt [2];

    state_t          state, state_n;
    logic [HW-1:0]   hold, hold_n;
    logic [WIDTH-1:0] pos_n;
    logic [1:0]      dir_n, dir_prev;
    logic            press_r, press_l, rev;
    logic [WIDTH:0]  step_v, up_full, dn_full;
    logic [WIDTH-1:0] pos_up, pos_dn, pos_mv, pos_ld;

    assign raw = {pb_l_n, pb_r_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 2'b11;
            s2 <= 2'b11;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= 2'b11;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_CYC - 1)) begin
                    db[i]     <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign press_r = ~db[0];
    assign press_l = ~db[1];

    always_comb begin
        dir_n = DIR_H;
        if (press_l && !press_r && (pos > MIN_V))
            dir_n = DIR_L;
        else if (press_r && !press_l && (pos < MAX_V))
            dir_n = DIR_R;
    end

    // Reversal drops back to slow speed, so that tick uses the small step.
    assign rev    = (dir != DIR_H) && (dir_prev != DIR_H) && (dir != dir_prev);
    assign step_v = (state == FAST && !rev) ? FSTEP_V : STEP_V;

    // One extra bit so neither direction can wrap before the clamp.
    assign up_full = {1'b0, pos} + step_v;
    assign dn_full = {1'b0, pos} - step_v;
    assign pos_up  = (up_full > MAX_W1) ? MAX_V : up_full[WIDTH-1:0];
    assign pos_dn  = (dn_full[WIDTH] || (dn_full < MIN_W1)) ? MIN_V : dn_full[WIDTH-1:0];
    assign pos_mv  = (dir == DIR_R) ? pos_up : pos_dn;
    assign pos_ld  = (load_val < MIN_V) ? MIN_V : ((load_val > MAX_V) ? MAX_V : load_val);

    always_comb begin
        state_n = state;
        hold_n  = hold;
        pos_n   = pos;
        if (load) begin
            pos_n   = pos_ld;
            state_n = IDLE;
            hold_n  = '0;
        end else if (dir == DIR_H) begin
            state_n = IDLE;
            hold_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SLOW;
                    hold_n  = '0;
                end
                default: begin
                    if (rev) begin
                        state_n = SLOW;
                        hold_n  = '0;
                        if (tick) pos_n = pos_mv;
                    end else if (tick) begin
                        pos_n = pos_mv;
                        if (state == SLOW) begin
                            hold_n = hold + HW'(1);
                            if (hold == HW'(HOLD_TICKS - 1)) state_n = FAST;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold     <= '0;
            pos      <= RST_V;
            dir      <= DIR_H;
            dir_prev <= DIR_H;
        end else begin
            state    <= state_n;
            hold     <= hold_n;
            pos      <= pos_n;
            dir      <= dir_n;
            dir_prev <= dir;
        end
    end

    assign at_min = (pos == MIN_V);
    assign at_max = (pos == MAX_V);
    assign moving = (state != IDLE);

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Scoreboarded bench for paddle_pos_ctrl: directed scenarios plus random button/tick/load traffic.
module tb_paddle_pos_ctrl;

    localparam int MINP = 15, MAXP = 624, RSTP = 320;
    localparam int STEP = 1, FSTEP = 4, HOLDT = 8, DEB = 16;

    logic       clk = 0, rst_n = 1;
    logic       pb_r_n = 1, pb_l_n = 1, tick = 0, load = 0;
    logic [9:0] load_val = 0;
    logic [9:0] pos;
    logic [1:0] dir;
    logic       at_min, at_max, moving;

    paddle_pos_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pb_r_n(pb_r_n), .pb_l_n(pb_l_n),
        .tick(tick), .load(load), .load_val(load_val),
        .pos(pos), .dir(dir), .at_min(at_min), .at_max(at_max), .moving(moving)
    );

    always #5 clk = ~clk;

    typedef struct {int pos; int dir; bit amin; bit amax; bit mov;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0;

    // reference: mode 0=idle 1=slow 2=fast; raw button history, newest at index 0
    int m_pos, m_dir, m_pdir, m_mode, m_held;
    bit m_db_r, m_db_l;
    bit hr[DEB+2];
    bit hl[DEB+2];

    function automatic int clampi(input int v);
        if (v < MINP) return MINP;
        if (v > MAXP) return MAXP;
        return v;
    endfunction

    function automatic void model_reset();
        m_pos = RSTP; m_dir = 2; m_pdir = 2; m_mode = 0; m_held = 0;
        m_db_r = 1; m_db_l = 1;
        for (int k = 0; k < DEB + 2; k++) begin hr[k] = 1; hl[k] = 1; end
    endfunction

    function automatic void model_edge(input bit r, input bit l, input bit t, input bit ld, input int lv);
        int nd, np, sgn;
        bit flip_r, flip_l;
        nd = 2;
        if (!m_db_l && m_db_r && m_pos > MINP) nd = 0;
        else if (!m_db_r && m_db_l && m_pos < MAXP) nd = 1;
        np = m_pos;
        sgn = (m_dir == 1) ? 1 : -1;
        if (ld) begin
            np = clampi(lv); m_mode = 0; m_held = 0;
        end else if (m_dir == 2) begin
            m_mode = 0; m_held = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_held = 0;
        end else if (m_pdir != 2 && m_pdir != m_dir) begin
            m_mode = 1; m_held = 0;
            if (t) np = clampi(m_pos + sgn * STEP);
        end else if (t) begin
            np = clampi(m_pos + sgn * ((m_mode == 2) ? FSTEP : STEP));
            if (m_mode == 1) begin
                m_held++;
                if (m_held == HOLDT) m_mode = 2;
            end
        end
        m_pos = np; m_pdir = m_dir; m_dir = nd;
        for (int k = DEB + 1; k > 0; k--) begin hr[k] = hr[k-1]; hl[k] = hl[k-1]; end
        hr[0] = r; hl[0] = l;
        // two sync stages, then DEB straight samples of the opposite level
        flip_r = 1; flip_l = 1;
        for (int k = 2; k < DEB + 2; k++) begin
            if (hr[k] == m_db_r) flip_r = 0;
            if (hl[k] == m_db_l) flip_l = 0;
        end
        if (flip_r) m_db_r = ~m_db_r;
        if (flip_l) m_db_l = ~m_db_l;
        q.push_back('{m_pos, m_dir, m_pos == MINP, m_pos == MAXP, m_mode != 0});
    endfunction

    task automatic step(input bit r, input bit l, input bit t, input bit ld, input int lv);
        @(negedge clk);
        pb_r_n = r; pb_l_n = l; tick = t; load = ld; load_val = 10'(lv);
        model_edge(r, l, t, ld, lv);
    endtask

    task automatic run(input bit r, input bit l, input int n);
        for (int i = 0; i < n; i++) step(r, l, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (pos != e.pos[9:0] || dir != e.dir[1:0] || at_min != e.amin ||
                at_max != e.amax || moving != e.mov) begin
                errors++;
                $display("FAIL sb act pos=%0d dir=%0d min=%0b max=%0b mov=%0b exp pos=%0d dir=%0d min=%0b max=%0b mov=%0b t=%0t",
                         pos, dir, at_min, at_max, moving, e.pos, e.dir, e.amin, e.amax, e.mov, $time);
            end
        end
    end

    initial begin
        int seg;
        bit rr, ll;
        model_reset();
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pos", pos, RSTP); chk("rst_dir", dir, 2); chk("rst_moving", moving, 0);
        chk("rst_at_min", at_min, 0); chk("rst_at_max", at_max, 0);
        @(negedge clk) rst_n = 1;

        // bounce on right, then a clean press
        for (int i = 0; i < 30; i++) begin
            step(((i / 3) % 2) != 0, 1, 0, 0, 0);
            settle();
            chk("bounce_dir", dir, 2);
        end
        for (int k = 1; k <= 22; k++) begin
            step(0, 1, 0, 0, 0);
            settle();
            chk("press_dir", dir, (k >= 19) ? 1 : 2);
        end
        step(0, 1, 1, 0, 0); settle(); chk("first_tick_pos", pos, 321);

        // acceleration from 320
        step(0, 1, 0, 1, 320); run(0, 1, 2);
        for (int n = 1; n <= 12; n++) begin
            step(0, 1, 1, 0, 0); settle();
            if (n == 8) chk("accel_slow_pos", pos, 328);
            if (n == 12) begin chk("accel_fast_pos", pos, 344); chk("accel_moving", moving, 1); end
            run(0, 1, 2);
        end

        // saturate at MAX while fast
        step(0, 1, 0, 1, 614); run(0, 1, 2);
        for (int n = 1; n <= 9; n++) begin step(0, 1, 1, 0, 0); run(0, 1, 1); end
        settle();
        chk("sat_max_pos", pos, MAXP); chk("sat_at_max", at_max, 1);
        run(0, 1, 2); settle(); chk("sat_max_dir", dir, 2);

        // push left into MIN
        run(1, 0, 22); step(1, 0, 0, 1, MINP); run(1, 0, 2);
        for (int n = 0; n < 3; n++) begin step(1, 0, 1, 0, 0); run(1, 0, 1); end
        settle();
        chk("sat_min_pos", pos, MINP); chk("sat_min_dir", dir, 2); chk("sat_at_min", at_min, 1);

        // both buttons, then out-of-range loads with tick
        run(0, 0, 22); step(0, 0, 0, 1, 300); run(0, 0, 2);
        for (int n = 0; n < 3; n++) begin step(0, 0, 1, 0, 0); run(0, 0, 1); end
        settle();
        chk("both_pos", pos, 300); chk("both_dir", dir, 2);
        step(0, 0, 1, 1, 900); settle(); chk("load_hi_pos", pos, MAXP); chk("load_hi_moving", moving, 0);
        step(0, 0, 1, 1, 3); settle(); chk("load_lo_pos", pos, MINP);

        // get to 500 in FAST, then async reset between edges
        run(0, 1, 22); step(0, 1, 0, 1, 480); run(0, 1, 2);
        for (int n = 0; n < 11; n++) begin step(0, 1, 1, 0, 0); run(0, 1, 1); end
        settle();
        chk("pre_rst_pos", pos, 500); chk("pre_rst_moving", moving, 1);
        #1 rst_n = 0; pb_r_n = 1; pb_l_n = 1; tick = 0; load = 0;
        #1;
        chk("arst_pos", pos, RSTP); chk("arst_dir", dir, 2); chk("arst_moving", moving, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;

        // random traffic
        seg = 0; rr = 1; ll = 1;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                rr = ($urandom_range(0, 1) != 0); ll = ($urandom_range(0, 1) != 0);
                seg = $urandom_range(5, 60);
            end
            seg--;
            step(rr, ll, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1023));
        end
        settle(); settle();
        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
